// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32I core.
// Sequences the shared ALU, the unified memory port and the register-file
// write port across several cycles per instruction. Memory accesses wait on
// mem_ready, so the core tolerates wait states.
//
// Optional feature macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
//   defined   -> unknown opcodes park the FSM in TRAP and set a sticky flag
//   undefined -> unknown opcodes retire as a NOP; illegal is tied to 0
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] imm_src,
   output logic       reg_write,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   state_t state_q, state_d;

   // Internal strobes combined into pc_write.
   logic pc_update;
   logic branch;
   // Raw enables before the reset gate.
   logic ir_write_raw;
   logic mem_write_raw;
   logic reg_write_raw;

   // State register; reset aborts any instruction in flight and returns to FETCH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTER;
               OP_I:         state_d = S_EXECUTEI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
               default:      state_d = S_TRAP;
`else
               // PC was already advanced in FETCH, so returning retires a NOP.
               default:      state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
         S_TRAP:     state_d = S_TRAP;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   // Per-state datapath controls; everything not named in a state stays 0.
   always_comb begin
      adr_src       = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_update     = 1'b0;
      branch        = 1'b0;
      ir_write_raw  = 1'b0;
      mem_write_raw = 1'b0;
      reg_write_raw = 1'b0;
      case (state_q)
         S_FETCH: begin
            // PC + 4 computed on the ALU and written straight back to PC.
            alu_src_b    = 2'b10;
            result_src   = 2'b10;
            ir_write_raw = mem_ready;
            pc_update    = mem_ready;
         end
         S_DECODE: begin
            // Branch/jump target precomputed from OldPC + imm.
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src    = 2'b01;
            reg_write_raw = 1'b1;
         end
         S_MEMWRITE: begin
            // Strobe held for the whole wait so memory sees a stable request.
            adr_src       = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXECUTER: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_write_raw = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch    = 1'b1;
         end
         S_JAL: begin
            // Link value OldPC + 4; target from DECODE lands in PC.
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   // Immediate format depends only on the opcode so it is valid from FETCH on.
   always_comb begin
      case (opcode)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   // Reset gates every write enable combinationally so nothing commits while it is held.
   assign pc_write  = ~reset & (pc_update | (branch & zero));
   assign ir_write  = ~reset & ir_write_raw;
   assign mem_write = ~reset & mem_write_raw;
   assign reg_write = ~reset & reg_write_raw;
   assign state     = state_q;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
   logic illegal_q;

   // Sticky illegal flag; only reset clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 illegal_q <= 1'b0;
      else if (state_q == S_TRAP) illegal_q <= 1'b1;
   end

   assign illegal = ~reset & (illegal_q | (state_q == S_TRAP));
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: hand-computed state sequences and
// control values for reset, R-type, lw with waits, sw aborted by reset, beq
// taken/not taken, jal and an unknown opcode.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
   logic [3:0] state;

   int n_vec = 0;
   int n_err = 0;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .imm_src(imm_src), .reg_write(reg_write), .state(state),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; opcode = 7'b0100011; zero = 1'b0; mem_ready = 1'b1;
      tick();
      tick();
      // Reset: FETCH values, enables forced low even with mem_ready high.
      chk("rst_state",  state, 0);
      chk("rst_pcw",    pc_write, 0);
      chk("rst_irw",    ir_write, 0);
      chk("rst_res",    result_src, 2'b10);
      chk("rst_b",      alu_src_b, 2'b10);
      chk("rst_imm_sw", imm_src, 2'b01);
      chk("rst_ill",    illegal, 0);
      #4 reset = 1'b0; mem_ready = 1'b0;
      tick();
      chk("fetch_hold", state, 0);
      chk("fetch_noirw", ir_write, 0);

      // R-type: 0,1,6,8,0
      opcode = 7'b0110011; mem_ready = 1'b1; #1;
      chk("r_s0", state, 0);
      chk("r_irw", ir_write, 1);
      chk("r_pcw", pc_write, 1);
      tick(); chk("r_s1", state, 1); chk("r_dec_a", alu_src_a, 2'b01); chk("r_dec_op", alu_op, 2'b00);
      tick(); chk("r_s6", state, 6); chk("r_op", alu_op, 2'b10); chk("r_rw3", reg_write, 0);
      chk("r_a", alu_src_a, 2'b10); chk("r_b", alu_src_b, 2'b00);
      tick(); chk("r_s8", state, 8); chk("r_rw4", reg_write, 1); chk("r_op4", alu_op, 2'b00);
      tick(); chk("r_s0b", state, 0);

      // lw with two wait cycles in MEMREAD: 0,1,2,3,3,3,4,0
      opcode = 7'b0000011;
      tick(); chk("lw_s1", state, 1);
      tick(); chk("lw_s2", state, 2); chk("lw_a", alu_src_a, 2'b10); chk("lw_b", alu_src_b, 2'b01);
      tick(); mem_ready = 1'b0; #1;
      chk("lw_s3a", state, 3); chk("lw_adr", adr_src, 1); chk("lw_rw_wait", reg_write, 0);
      tick(); chk("lw_s3b", state, 3);
      tick(); chk("lw_s3c", state, 3); mem_ready = 1'b1;
      tick(); chk("lw_s4", state, 4); chk("lw_res", result_src, 2'b01); chk("lw_rw", reg_write, 1);
      tick(); chk("lw_s0", state, 0);

      // sw stalled in MEMWRITE, then aborted by reset.
      opcode = 7'b0100011;
      tick(); chk("sw_s1", state, 1);
      tick(); chk("sw_s2", state, 2);
      tick(); mem_ready = 1'b0; #1;
      chk("sw_s5", state, 5); chk("sw_mw", mem_write, 1); chk("sw_imm", imm_src, 2'b01);
      tick(); chk("sw_s5w", state, 5); chk("sw_mw_wait", mem_write, 1);
      #2 reset = 1'b1; #1;
      chk("abort_state", state, 0);
      chk("abort_mw", mem_write, 0);
      mem_ready = 1'b1; #1;
      chk("abort_irw", ir_write, 0);
      chk("abort_pcw", pc_write, 0);
      #2 reset = 1'b0; mem_ready = 1'b0;
      tick(); chk("post_rst", state, 0);

      // beq taken then not taken.
      opcode = 7'b1100011; zero = 1'b1; mem_ready = 1'b1;
      tick(); chk("beq1_s1", state, 1); chk("beq_imm", imm_src, 2'b10);
      tick(); chk("beq1_s9", state, 9); chk("beq1_pcw", pc_write, 1); chk("beq1_op", alu_op, 2'b01);
      tick(); chk("beq1_s0", state, 0); zero = 1'b0;
      tick(); chk("beq0_s1", state, 1);
      tick(); chk("beq0_s9", state, 9); chk("beq0_pcw", pc_write, 0); chk("beq0_op", alu_op, 2'b01);
      tick(); chk("beq0_s0", state, 0);

      // jal: 0,1,10,8
      opcode = 7'b1101111; #1;
      chk("jal_imm0", imm_src, 2'b11);
      tick(); chk("jal_s1", state, 1); chk("jal_imm1", imm_src, 2'b11);
      tick(); chk("jal_s10", state, 10); chk("jal_pcw", pc_write, 1);
      chk("jal_a", alu_src_a, 2'b01); chk("jal_b", alu_src_b, 2'b10); chk("jal_imm2", imm_src, 2'b11);
      tick(); chk("jal_s8", state, 8); chk("jal_rw", reg_write, 1);
      tick(); chk("jal_s0", state, 0);

      // Unknown opcode.
      opcode = 7'b0000000;
      tick(); chk("ill_s1", state, 1);
      tick();
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      chk("ill_s11", state, 11); chk("ill_flag", illegal, 1);
      chk("ill_pcw", pc_write, 0); chk("ill_irw", ir_write, 0); chk("ill_rw", reg_write, 0);
      tick(); chk("ill_hold", state, 11); chk("ill_flag2", illegal, 1);
      reset = 1'b1; #1;
      chk("ill_rst_s", state, 0); chk("ill_rst_flag", illegal, 0);
      #2 reset = 1'b0;
`else
      chk("ill_nop_s0", state, 0); chk("ill_flag0", illegal, 0); chk("ill_rw", reg_write, 0);
      tick(); chk("ill_nop_s1", state, 1); chk("ill_flag1", illegal, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
